sqrt_seq_ctrl: RTL

//  Sequencer and result stage upstream/downstream of the non-restoring sqrt datapath.

---
 rtl/sqrt_pkg.sv | 33 +++
 rtl/sqrt_rem_fix.sv | 29 ++
 rtl/sqrt_seq_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and sizing helpers for the sequential square-root
// control block and its result-correction stage.
//   sqrt_state_t   : sequencer states
//   sqrt_iters()   : number of iteration steps (root width) for a radicand width
//   sqrt_rem_w()   : width of the corrected, unsigned remainder
//   sqrt_dprem_w() : width of the datapath's signed partial remainder
package sqrt_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } sqrt_state_t;

  localparam int SQRT_DW_DEFAULT = 16;

  function automatic int sqrt_iters(input int dw);
    return dw / 2;
  endfunction

  function automatic int sqrt_rem_w(input int dw2);
    return dw2 + 1;
  endfunction

  // The non-restoring remainder spans [-(2Q+1), 2Q]; two bits beyond the
  // root width keep its sign unambiguous up to D = 2^DW-1.
  function automatic int sqrt_dprem_w(input int dw2);
    return dw2 + 2;
  endfunction

endpackage

// File: rtl/sqrt_rem_fix.sv
// sqrt_rem_fix: combinational correction of the final non-restoring remainder.
// Ports:
//   i_q   [DW_2-1:0] final root from the datapath
//   i_rem [DW_2+1:0] final remainder, two's complement
//   o_rem [DW_2:0]   D - root^2, unsigned
// A negative remainder is lifted by 2*root+1; the add is done modulo 2^(DW_2+1),
// which is exact because the true result always lies in [0, 2*root].
module sqrt_rem_fix #(
  parameter int DW_2 = 8
) (
  input  logic [DW_2-1:0] i_q,
  input  logic [DW_2+1:0] i_rem,
  output logic [DW_2:0]   o_rem
);

  logic [DW_2:0] w_sum;

  // Add {root,1} only when the remainder sign bit is set.
  always_comb begin
    w_sum = i_rem[DW_2:0];
    if (i_rem[DW_2+1]) begin
      w_sum = i_rem[DW_2:0] + {i_q, 1'b1};
    end else begin
      w_sum = i_rem[DW_2:0];
    end
    o_rem = w_sum;
  end

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// sqrt_seq_ctrl: sequencer and result stage around a non-restoring sqrt datapath.
// Takes a radicand over in_valid/in_ready, clears the datapath for one cycle,
// steps it DW_2 times with a descending bit-pair shift count, corrects the
// final remainder and holds {root, remainder} until out_ready.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data       radicand handshake
//   dp_rst_n, dp_load, dp_start,    datapath controls (dp_load low = iterate)
//   dp_ctrl, dp_D, dp_excounter
//   dp_Q, dp_rem                    datapath root / signed remainder
//   out_valid/out_ready/out_root/out_rem   result handshake
//   busy                            sequencer not idle
module sqrt_seq_ctrl
  import sqrt_pkg::*;
#(
  parameter int DW   = SQRT_DW_DEFAULT,
  parameter int DW_2 = sqrt_iters(DW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            dp_rst_n,
  output logic            dp_load,
  output logic            dp_start,
  output logic            dp_ctrl,
  output logic [DW-1:0]   dp_D,
  output logic [DW-1:0]   dp_excounter,
  input  logic [DW_2-1:0] dp_Q,
  input  logic [DW_2+1:0] dp_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_2-1:0] out_root,
  output logic [DW_2:0]   out_rem,
  output logic            busy
);

  sqrt_state_t     r_state, w_state_nx;
  logic [DW-1:0]   r_dp_d, w_dp_d_nx;
  logic [DW-1:0]   r_excnt, w_excnt_nx;
  logic [DW_2-1:0] r_iter, w_iter_nx;
  logic [DW_2-1:0] r_root, w_root_nx;
  logic [DW_2:0]   r_rem, w_rem_nx;
  logic [DW_2:0]   w_rem_fixed;
  logic            r_clr_n, w_clr_n_nx;
  logic            r_load, w_load_nx;
  logic            r_start, w_start_nx;
  logic            r_ctrl, w_ctrl_nx;
  logic            r_in_ready, w_in_ready_nx;
  logic            r_out_valid, w_out_valid_nx;
  logic            r_busy, w_busy_nx;

  sqrt_rem_fix #(.DW_2(DW_2)) u_rem_fix (
    .i_q   (dp_Q),
    .i_rem (dp_rem),
    .o_rem (w_rem_fixed)
  );

  // Next-state, datapath sequencing and next values of the registered outputs.
  always_comb begin
    w_state_nx = r_state;
    w_dp_d_nx  = r_dp_d;
    w_excnt_nx = r_excnt;
    w_iter_nx  = r_iter;
    w_root_nx  = r_root;
    w_rem_nx   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nx = S_CLEAR;
          w_dp_d_nx  = in_data;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_state_nx = S_ITER;
        w_excnt_nx = DW'(DW - 2);
        w_iter_nx  = DW_2'(DW_2 - 1);
      end
      S_ITER: begin
        // Counters stop at zero on the last step so they never wrap.
        if (r_iter == DW_2'(0)) begin
          w_state_nx = S_FIX;
        end else begin
          w_excnt_nx = r_excnt - DW'(2);
          w_iter_nx  = r_iter - DW_2'(1);
        end
      end
      S_FIX: begin
        w_state_nx = S_DONE;
        w_root_nx  = dp_Q;
        w_rem_nx   = w_rem_fixed;
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave flops cleanly.
    w_load_nx      = (w_state_nx != S_ITER);
    w_start_nx     = (w_state_nx == S_ITER) && (r_state == S_CLEAR);
    w_ctrl_nx      = (w_state_nx == S_ITER) && (w_iter_nx == DW_2'(0));
    w_clr_n_nx     = (w_state_nx != S_CLEAR);
    w_in_ready_nx  = (w_state_nx == S_IDLE);
    w_out_valid_nx = (w_state_nx == S_DONE);
    w_busy_nx      = (w_state_nx != S_IDLE);
  end

  // State, datapath-control and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dp_d      <= DW'(0);
      r_excnt     <= DW'(0);
      r_iter      <= DW_2'(0);
      r_root      <= DW_2'(0);
      r_rem       <= (DW_2 + 1)'(0);
      r_clr_n     <= 1'b1;
      r_load      <= 1'b1;
      r_start     <= 1'b0;
      r_ctrl      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_dp_d      <= w_dp_d_nx;
      r_excnt     <= w_excnt_nx;
      r_iter      <= w_iter_nx;
      r_root      <= w_root_nx;
      r_rem       <= w_rem_nx;
      r_clr_n     <= w_clr_n_nx;
      r_load      <= w_load_nx;
      r_start     <= w_start_nx;
      r_ctrl      <= w_ctrl_nx;
      r_in_ready  <= w_in_ready_nx;
      r_out_valid <= w_out_valid_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Gating with reset holds in_ready and dp_rst_n low during reset while
  // letting a radicand already offered be taken on the first clock after release.
  assign in_ready     = reset & r_in_ready;
  assign dp_rst_n     = reset & r_clr_n;
  assign dp_load      = r_load;
  assign dp_start     = r_start;
  assign dp_ctrl      = r_ctrl;
  assign dp_D         = r_dp_d;
  assign dp_excounter = r_excnt;
  assign out_valid    = r_out_valid;
  assign out_root     = r_root;
  assign out_rem      = r_rem;
  assign busy         = r_busy;

endmodule
